// File: rtl/input_deserializer_if.sv
// Nibble stream in, assembled 32-bit word out, with valid/ready on the word side.
// Pure signal bundle, no logic and no added latency.
// data_ready from the consumer is the only backpressure; the nibble side has none.
interface input_deserializer_if;
    logic [3:0]  serial_in;
    logic        serial_in_valid;
    logic        data_ready;
    logic [31:0] data_out;
    logic        data_out_valid;

    // Producer/consumer side (testbench or upstream/downstream logic)
    modport master (
        output serial_in,
        output serial_in_valid,
        output data_ready,
        input  data_out,
        input  data_out_valid
    );

    // Deserializer side
    modport slave (
        input  serial_in,
        input  serial_in_valid,
        input  data_ready,
        output data_out,
        output data_out_valid
    );
endinterface

// File: rtl/input_deserializer.sv
// Collects 8 nibbles (LS nibble first) into a 32-bit word held in a one-entry output buffer.
// Latency: word valid the cycle after the 8th nibble is sampled; idle gaps of TIMEOUT cycles abort.
// Backpressure: none upstream; a word completing into a full, unconsumed buffer is dropped (overflow).
module input_deserializer #(
    parameter int unsigned TIMEOUT = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input_deserializer_if.slave        bus,
    output logic                       deser_busy,
    output logic                       frame_error,
    output logic                       overflow,
    output logic [7:0]                 err_count
);

    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] COLLECT = 1'b1;

    localparam logic [7:0] GAP_LIMIT = 8'(TIMEOUT);

    logic [0:0]  state;
    logic [2:0]  idx;
    logic [7:0]  gap;
    logic [31:0] shreg;
    logic [31:0] out_dat;
    logic        out_vld;

    logic [31:0] word_next;
    logic [7:0]  gap_inc;
    logic        complete;
    logic        timeout_hit;
    logic        load;
    logic        drop;
    logic        consume;

    // Next-word merge and event decode for this cycle
    always_comb begin
        word_next                      = shreg;
        word_next[{idx, 2'b00} +: 4]   = bus.serial_in;
        gap_inc     = gap + 8'd1;
        complete    = bus.serial_in_valid && (state == COLLECT) && (idx == 3'd7);
        timeout_hit = !bus.serial_in_valid && (state == COLLECT) && (gap_inc == GAP_LIMIT);
        consume     = out_vld && bus.data_ready;
        // Completion may refill the buffer in the same cycle it is drained
        load        = complete && (!out_vld || bus.data_ready);
        drop        = complete && out_vld && !bus.data_ready;
    end

    // Collection state: nibble index, gap counter and partial word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= 3'd0;
            gap   <= 8'd0;
            shreg <= 32'd0;
        end else if (flush) begin
            state <= IDLE;
            idx   <= 3'd0;
            gap   <= 8'd0;
        end else if (bus.serial_in_valid) begin
            shreg <= word_next;
            gap   <= 8'd0;
            if (complete) begin
                state <= IDLE;
                idx   <= 3'd0;
            end else begin
                state <= COLLECT;
                idx   <= idx + 3'd1;
            end
        end else if (state == COLLECT) begin
            if (timeout_hit) begin
                state <= IDLE;
                idx   <= 3'd0;
                gap   <= 8'd0;
            end else begin
                gap <= gap_inc;
            end
        end
    end

    // One-entry output buffer: load on completion, drain on valid&ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_dat <= 32'd0;
            out_vld <= 1'b0;
        end else if (flush) begin
            out_dat <= 32'd0;
            out_vld <= 1'b0;
        end else if (load) begin
            out_dat <= word_next;
            out_vld <= 1'b1;
        end else if (consume) begin
            out_vld <= 1'b0;
        end
    end

    // Error pulses and saturating error counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_error <= 1'b0;
            overflow    <= 1'b0;
            err_count   <= 8'd0;
        end else begin
            frame_error <= !flush && timeout_hit;
            overflow    <= !flush && drop;
            if (!flush && (timeout_hit || drop) && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

    assign deser_busy         = (state == COLLECT);
    assign bus.data_out       = out_dat;
    assign bus.data_out_valid = out_vld;

endmodule

// File: tb/tb_input_deserializer.sv
// Self-checking bench for input_deserializer: directed table, corner sequences, random vs model.
// Inputs driven 1 time unit after the rising edge; outputs sampled at the same offset.
// Reference model tracks the partial word as a queue of nibbles and the buffer as valid+data.
module tb_input_deserializer;

    localparam int TB_TIMEOUT = 4;

    logic       clk;
    logic       rst_n;
    logic       flush;
    logic       deser_busy;
    logic       frame_error;
    logic       overflow;
    logic [7:0] err_count;

    input_deserializer_if bus();

    input_deserializer #(.TIMEOUT(TB_TIMEOUT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .bus         (bus),
        .deser_busy  (deser_busy),
        .frame_error (frame_error),
        .overflow    (overflow),
        .err_count   (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // ---------------- reference model ----------------
    int          part[$];
    int          m_gap;
    logic        m_vld;
    logic [31:0] m_dat;
    int          m_err;
    logic        m_fe;
    logic        m_ov;

    task automatic model_reset();
        part.delete();
        m_gap = 0; m_vld = 1'b0; m_dat = 32'd0; m_err = 0; m_fe = 1'b0; m_ov = 1'b0;
    endtask

    task automatic model_step(input logic f, input logic v, input logic [3:0] n, input logic r);
        logic [31:0] w;
        m_fe = 1'b0;
        m_ov = 1'b0;
        if (f) begin
            part.delete();
            m_gap = 0;
            m_vld = 1'b0;
            m_dat = 32'd0;
        end else begin
            if (m_vld && r) m_vld = 1'b0;
            if (v) begin
                part.push_back(int'(n));
                m_gap = 0;
                if (part.size() == 8) begin
                    w = 32'd0;
                    foreach (part[k]) w = w + (32'(part[k]) << (4 * k));
                    part.delete();
                    if (m_vld) begin
                        m_ov = 1'b1;
                        if (m_err < 255) m_err++;
                    end else begin
                        m_vld = 1'b1;
                        m_dat = w;
                    end
                end
            end else if (part.size() > 0) begin
                m_gap++;
                if (m_gap == TB_TIMEOUT) begin
                    part.delete();
                    m_gap = 0;
                    m_fe = 1'b1;
                    if (m_err < 255) m_err++;
                end
            end
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic compare_model();
        chk("mdl_vld",  32'(bus.data_out_valid), 32'(m_vld));
        chk("mdl_dat",  bus.data_out, m_dat);
        chk("mdl_busy", 32'(deser_busy), 32'(part.size() > 0));
        chk("mdl_fe",   32'(frame_error), 32'(m_fe));
        chk("mdl_ov",   32'(overflow), 32'(m_ov));
        chk("mdl_err",  32'(err_count), 32'(m_err));
    endtask

    // One clock: drive inputs, take the edge, advance model, compare
    task automatic cyc(input logic f, input logic v, input logic [3:0] n, input logic r);
        flush = f;
        bus.serial_in_valid = v;
        bus.serial_in = n;
        bus.data_ready = r;
        @(posedge clk);
        model_step(f, v, n, r);
        #1;
        compare_model();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        flush = 1'b0;
        bus.serial_in_valid = 1'b0;
        bus.serial_in = 4'h0;
        bus.data_ready = 1'b0;
        #2;
        chk("rst_dat",  bus.data_out, 32'd0);
        chk("rst_vld",  32'(bus.data_out_valid), 32'd0);
        chk("rst_busy", 32'(deser_busy), 32'd0);
        chk("rst_fe",   32'(frame_error), 32'd0);
        chk("rst_ov",   32'(overflow), 32'd0);
        chk("rst_err",  32'(err_count), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap_cycles, input logic r);
        for (int k = 0; k < 8; k++) begin
            cyc(1'b0, 1'b1, w[4*k +: 4], r);
            if (k < 7) repeat (gap_cycles) cyc(1'b0, 1'b0, 4'h0, r);
        end
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic        f;
        logic        v;
        logic [3:0]  n;
        logic        r;
        logic        e_vld;
        logic [31:0] e_dat;
        logic        e_busy;
        logic        e_fe;
        logic        e_ov;
        logic [7:0]  e_err;
    } vec_t;

    vec_t tbl [9];

    initial begin
        logic [3:0]  db_nib [8];
        logic [31:0] w;
        int          fe_cnt;
        int          idle_cnt;
        int          ov_cnt;
        int          pv;
        logic        f, v, r;
        logic [3:0]  n;

        db_nib = '{4'hF, 4'hE, 4'hE, 4'hB, 4'hD, 4'hA, 4'hE, 4'hD};
        for (int k = 0; k < 7; k++)
            tbl[k] = '{1'b0, 1'b1, db_nib[k], 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 8'd0};
        tbl[7] = '{1'b0, 1'b1, db_nib[7], 1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[8] = '{1'b0, 1'b0, 4'h0,      1'b1, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 8'd0};

        rst_n = 1'b1;
        flush = 1'b0;
        bus.serial_in_valid = 1'b0;
        bus.serial_in = 4'h0;
        bus.data_ready = 1'b0;
        #1;
        do_reset();

        // Back-to-back DEADBEEF, valid for exactly one cycle
        for (int k = 0; k < 9; k++) begin
            cyc(tbl[k].f, tbl[k].v, tbl[k].n, tbl[k].r);
            chk($sformatf("tbl%0d_vld", k),  32'(bus.data_out_valid), 32'(tbl[k].e_vld));
            chk($sformatf("tbl%0d_dat", k),  bus.data_out, tbl[k].e_dat);
            chk($sformatf("tbl%0d_busy", k), 32'(deser_busy), 32'(tbl[k].e_busy));
            chk($sformatf("tbl%0d_fe", k),   32'(frame_error), 32'(tbl[k].e_fe));
            chk($sformatf("tbl%0d_ov", k),   32'(overflow), 32'(tbl[k].e_ov));
            chk($sformatf("tbl%0d_err", k),  32'(err_count), 32'(tbl[k].e_err));
        end

        // Maximum tolerated gap (TIMEOUT-1 idles) between every nibble
        do_reset();
        fe_cnt = 0;
        idle_cnt = 0;
        w = 32'hDEADBEEF;
        for (int k = 0; k < 8; k++) begin
            cyc(1'b0, 1'b1, w[4*k +: 4], 1'b1);
            if (frame_error) fe_cnt++;
            if (k < 7 && !deser_busy) idle_cnt++;
            if (k < 7) begin
                for (int g = 0; g < TB_TIMEOUT - 1; g++) begin
                    cyc(1'b0, 1'b0, 4'h0, 1'b1);
                    if (frame_error) fe_cnt++;
                    if (!deser_busy) idle_cnt++;
                end
            end
        end
        chk("gap_dat", bus.data_out, 32'hDEADBEEF);
        chk("gap_vld", 32'(bus.data_out_valid), 32'd1);
        chk("gap_fe_count", 32'(fe_cnt), 32'd0);
        chk("gap_busy_drop", 32'(idle_cnt), 32'd0);

        // Timeout abort, then a clean word right after
        do_reset();
        for (int k = 0; k < 3; k++) cyc(1'b0, 1'b1, 4'(k + 9), 1'b1);
        for (int g = 0; g < TB_TIMEOUT - 1; g++) cyc(1'b0, 1'b0, 4'h0, 1'b1);
        chk("to_pre_fe", 32'(frame_error), 32'd0);
        cyc(1'b0, 1'b0, 4'h0, 1'b1);
        chk("to_fe",   32'(frame_error), 32'd1);
        chk("to_err",  32'(err_count), 32'd1);
        chk("to_busy", 32'(deser_busy), 32'd0);
        cyc(1'b0, 1'b1, 4'h1, 1'b1);
        chk("to_fe_pulse", 32'(frame_error), 32'd0);
        for (int k = 1; k < 8; k++) cyc(1'b0, 1'b1, 4'(k + 1), 1'b1);
        chk("to_next_dat", bus.data_out, 32'h87654321);
        chk("to_next_vld", 32'(bus.data_out_valid), 32'd1);

        // Overflow: second word completes into a full buffer
        do_reset();
        send_word(32'h11111111, 0, 1'b0);
        chk("ov_first", bus.data_out, 32'h11111111);
        ov_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            cyc(1'b0, 1'b1, 4'h2, 1'b0);
            if (overflow) ov_cnt++;
        end
        chk("ov_pulse", 32'(overflow), 32'd1);
        chk("ov_keep",  bus.data_out, 32'h11111111);
        chk("ov_err",   32'(err_count), 32'd1);
        cyc(1'b0, 1'b0, 4'h0, 1'b1);
        chk("ov_once",   32'(ov_cnt + int'(overflow)), 32'd1);
        chk("ov_consumed", 32'(bus.data_out_valid), 32'd0);

        // Completion coinciding with consumption reloads without overflow
        send_word(32'hA5A5A5A5, 0, 1'b0);
        for (int k = 0; k < 7; k++) cyc(1'b0, 1'b1, 4'h3, 1'b0);
        cyc(1'b0, 1'b1, 4'h3, 1'b1);
        chk("cc_vld", 32'(bus.data_out_valid), 32'd1);
        chk("cc_dat", bus.data_out, 32'h33333333);
        chk("cc_ov",  32'(overflow), 32'd0);

        // Reset mid-word, then a fresh word
        do_reset();
        for (int k = 0; k < 5; k++) cyc(1'b0, 1'b1, 4'h7, 1'b1);
        do_reset();
        send_word(32'hCAFEF00D, 0, 1'b1);
        chk("rw_dat", bus.data_out, 32'hCAFEF00D);

        // Flush mid-word: silent, err_count kept, valid nibble that cycle ignored
        cyc(1'b0, 1'b0, 4'h0, 1'b1);
        for (int k = 0; k < 3; k++) cyc(1'b0, 1'b1, 4'h5, 1'b1);
        for (int g = 0; g < TB_TIMEOUT; g++) cyc(1'b0, 1'b0, 4'h0, 1'b1);
        for (int k = 0; k < 5; k++) cyc(1'b0, 1'b1, 4'h6, 1'b1);
        cyc(1'b1, 1'b1, 4'h9, 1'b1);
        chk("fl_busy", 32'(deser_busy), 32'd0);
        chk("fl_fe",   32'(frame_error), 32'd0);
        chk("fl_err",  32'(err_count), 32'd1);
        for (int g = 0; g < TB_TIMEOUT + 1; g++) cyc(1'b0, 1'b0, 4'h0, 1'b1);
        chk("fl_no_late_fe", 32'(err_count), 32'd1);
        send_word(32'h0BADF00D, 0, 1'b1);
        chk("fl_next_dat", bus.data_out, 32'h0BADF00D);

        // Error counter saturation
        do_reset();
        for (int a = 0; a < 260; a++) begin
            cyc(1'b0, 1'b1, 4'h1, 1'b1);
            for (int g = 0; g < TB_TIMEOUT; g++) cyc(1'b0, 1'b0, 4'h0, 1'b1);
        end
        chk("sat_err", 32'(err_count), 32'd255);
        cyc(1'b0, 1'b1, 4'h1, 1'b1);
        for (int g = 0; g < TB_TIMEOUT; g++) cyc(1'b0, 1'b0, 4'h0, 1'b1);
        chk("sat_hold", 32'(err_count), 32'd255);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            case ((i / 250) % 3)
                0:       pv = 90;
                1:       pv = 60;
                default: pv = 35;
            endcase
            f = ($urandom_range(0, 149) == 0);
            v = ($urandom_range(0, 99) < pv);
            n = 4'($urandom_range(0, 15));
            r = ($urandom_range(0, 1) == 1);
            cyc(f, v, n, r);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/input_deserializer.md
INPUT_DESERIALIZER -- requirements
Module: input_deserializer

Interface
REQ-001 SHALL provide parameter TIMEOUT, default 4, meaning the number of consecutive idle cycles inside a word that aborts the word (legal range 1..255).
REQ-002 SHALL have port clk  input  1  clock; all state changes on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port flush  input  1  synchronous clear of the partial word and the output buffer.
REQ-005 SHALL have port serial_in  input  4  incoming nibble, least-significant nibble first.
REQ-006 SHALL have port serial_in_valid  input  1  serial_in carries a valid nibble this cycle.
REQ-007 SHALL have port data_ready  input  1  downstream accepts data_out this cycle.
REQ-008 SHALL have port data_out  output  32  assembled word (output buffer).
REQ-009 SHALL have port data_out_valid  output  1  output buffer holds an unconsumed word.
REQ-010 SHALL have port deser_busy  output  1  a partial word is being collected.
REQ-011 SHALL have port frame_error  output  1  one-cycle pulse: word aborted by timeout.
REQ-012 SHALL have port overflow  output  1  one-cycle pulse: completed word dropped because the buffer was full.
REQ-013 SHALL have port err_count  output  8  saturating count of frame_error plus overflow events.

Function
REQ-014 SHALL implement two collection states: IDLE (nibble index 0, no partial word) and COLLECT.
REQ-015 SHALL, in IDLE with serial_in_valid=1, write serial_in to bits [3:0], set index to 1 and enter COLLECT.
REQ-016 SHALL, in COLLECT with serial_in_valid=1, write serial_in to bits [4*i+3:4*i] at index i, increment i and clear the gap counter.
REQ-017 SHALL, when i=7 is written, complete the word, return to IDLE and reset the index to 0.
REQ-018 SHALL, in COLLECT with serial_in_valid=0, increment the gap counter by one each cycle.
REQ-019 SHALL, when the gap counter reaches TIMEOUT, discard the partial word, return to IDLE and pulse frame_error for one cycle.
REQ-020 SHALL therefore tolerate gaps of up to TIMEOUT-1 idle cycles between nibbles of one word.
REQ-021 SHALL drive deser_busy=1 exactly while in COLLECT.
REQ-022 SHALL load a completed word into the output buffer at the same edge as the 8th nibble, so data_out_valid=1 in the cycle after the 8th nibble is sampled; 8 back-to-back nibbles yield a word 8 edges after the first nibble.
REQ-023 SHALL treat a word as consumed on any edge where data_out_valid=1 and data_ready=1, after which data_out_valid goes to 0 unless a new word loads at the same edge.
REQ-024 SHALL load the new word when completion coincides with consumption; data_out_valid stays 1 and no overflow occurs.
REQ-025 SHALL, when a word completes while data_out_valid=1 and data_ready=0, drop the new word, keep data_out unchanged and pulse overflow for one cycle.
REQ-026 SHALL keep data_out stable while data_out_valid=1 and the word is not consumed.
REQ-027 SHALL increment err_count by 1 on each frame_error or overflow pulse and saturate at 255 without wrapping.
REQ-028 SHALL give flush=1 priority over all other inputs: return to IDLE, clear index, gap counter and data_out_valid, ignore serial_in_valid that cycle, raise no error pulse, and leave err_count unchanged.
REQ-029 SHALL accept a valid nibble in the cycle immediately after completion, after an abort, or after a flush as the index-0 nibble of a new word.

Reset
REQ-030 SHALL, while rst_n=0, asynchronously force IDLE with index and gap counter 0, and drive data_out=0, data_out_valid=0, deser_busy=0, frame_error=0, overflow=0 and err_count=0.
REQ-031 SHALL, when reset asserts mid-word, lose the partial word silently with no error pulse, and the first valid nibble after release SHALL be treated as nibble 0.

Verification
REQ-032 SHALL be checked by: nibbles F,E,E,B,D,A,E,D on 8 consecutive cycles with data_ready=1 -> data_out=0xDEADBEEF, data_out_valid=1 for exactly one cycle starting the cycle after the 8th nibble.
REQ-033 SHALL be checked by: TIMEOUT=4, the same word with 3 idle cycles between every nibble -> 0xDEADBEEF, frame_error never pulses, deser_busy=1 throughout.
REQ-034 SHALL be checked by: 3 nibbles then 4 idle cycles -> one-cycle frame_error, err_count=1, deser_busy=0; next 8 nibbles 1..8 -> data_out=0x87654321.
REQ-035 SHALL be checked by: data_ready=0, words 0x11111111 then 0x22222222 back-to-back -> data_out remains 0x11111111, overflow pulses once, err_count=1; data_ready=1 then consumes 0x11111111.
REQ-036 SHALL be checked by: rst_n low after 5 nibbles, then released -> all outputs 0; the following 8 nibbles form the correct word; separately flush after 5 nibbles -> no error pulse and err_count unchanged.
REQ-037 SHALL be checked by: 260 timeout aborts -> err_count=255 and held there.
